// File: rtl/pipelined_rca.sv
// Purpose: ripple-carry adder/subtractor split into NSEG = WIDTH/SEG_W registered segment stages.
// Latency: NSEG cycles from acceptance to result; one result per cycle when unstalled.
// Backpressure: whole pipe freezes while a result sits unaccepted; in_ready = advance && !rst.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin, sub)
//   a, b                WIDTH-bit operands; sub=1 computes a-b, cin ignored
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   sum, cout, ovf      result bits, carry out of MSB (1 = no borrow on sub), signed overflow
module pipelined_rca #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = (SEG_W > 0) ? WIDTH / SEG_W : 1;

    if (SEG_W < 1 || WIDTH < SEG_W || (WIDTH % ((SEG_W > 0) ? SEG_W : 1)) != 0) begin : g_param_check
        $error("pipelined_rca: WIDTH must be a positive multiple of SEG_W");
    end

    // Every stage moves together; bubbles advance too so the pipe refills
    // behind an output that was stalled and then released.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int WIN = WIDTH - k * SEG_W;   // operand bits still to be added on entry
        localparam int RW  = WIN - SEG_W;         // operand bits carried on to later stages
        localparam int SW  = (k + 1) * SEG_W;     // sum bits known after this stage

        logic [WIN-1:0]   a_in;
        logic [WIN-1:0]   b_in;
        logic             c_in;
        logic             v_in;
        logic [SW-1:0]    sum_d;
        logic [SEG_W-1:0] a_seg;
        logic [SEG_W-1:0] b_seg;
        logic [SEG_W:0]   seg;

        logic             v_q;
        logic             c_q;
        logic [SW-1:0]    sum_q;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1: invert B once here, force carry-in to 1.
            assign a_in  = a;
            assign b_in  = b ^ {WIDTH{sub}};
            assign c_in  = sub | cin;
            assign v_in  = in_valid && in_ready;
            assign sum_d = seg[SEG_W-1:0];
        end else begin : g_next
            assign a_in  = g_stage[k-1].g_rem.a_q;
            assign b_in  = g_stage[k-1].g_rem.b_q;
            assign c_in  = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;
            assign sum_d = {seg[SEG_W-1:0], g_stage[k-1].sum_q};
        end

        assign a_seg = a_in[SEG_W-1:0];
        assign b_seg = b_in[SEG_W-1:0];
        assign seg   = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, c_in};

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                v_q   <= v_in;
                c_q   <= seg[SEG_W];
                sum_q <= sum_d;
            end
        end

        // Only the operand bits not yet consumed travel down the pipe.
        if (RW > 0) begin : g_rem
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[WIN-1:SEG_W];
                    b_q <= b_in[WIN-1:SEG_W];
                end
            end
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in.
    logic msb_cin;
    logic ovf_d;
    assign msb_cin = g_stage[NSEG-1].a_seg[SEG_W-1]
                   ^ g_stage[NSEG-1].b_seg[SEG_W-1]
                   ^ g_stage[NSEG-1].seg[SEG_W-1];
    assign ovf_d   = msb_cin ^ g_stage[NSEG-1].seg[SEG_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (advance) begin
            ovf <= ovf_d;
        end
    end

    assign out_valid = g_stage[NSEG-1].v_q;
    assign sum       = g_stage[NSEG-1].sum_q;
    assign cout      = g_stage[NSEG-1].c_q;

endmodule

// File: tb/tb_pipelined_rca.sv
module tb_pipelined_rca;

    localparam int W = 16;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         cin;
    logic         sub;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic         ovf;
    logic [W-1:0] sum;

    logic         in_valid8;
    logic         cin8;
    logic         sub8;
    logic         out_ready8;
    logic [7:0]   a8;
    logic [7:0]   b8;
    logic         in_ready8;
    logic         out_valid8;
    logic         cout8;
    logic         ovf8;
    logic [7:0]   sum8;

    pipelined_rca #(.WIDTH(16), .SEG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_rca #(.WIDTH(8), .SEG_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   rnd_ready = 0;

    // Reference: plain integer arithmetic, overflow from the signed range.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        exp_t         m;
        logic [W-1:0] opb = sb ? ~y : y;
        logic         c   = sb ? 1'b1 : ci;
        logic [W:0]   t   = {1'b0, x} + {1'b0, opb} + {{W{1'b0}}, c};
        int           st  = int'($signed(x)) + int'($signed(opb)) + int'(c);
        m.s = t[W-1:0];
        m.c = t[W];
        m.o = (st > 32767) || (st < -32768);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        int n = 0;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(model(x, y, ci, sb));
                tick();
                break;
            end
            tick();
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: every presented result must equal the oldest pending
    // expectation, held there for as long as it is stalled.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else if (out_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: sum=%0h with nothing pending", sum);
            end else begin
                chk("sum",  {16'd0, sum}, {16'd0, q[0].s});
                chk("cout", {31'd0, cout}, {31'd0, q[0].c});
                chk("ovf",  {31'd0, ovf},  {31'd0, q[0].o});
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        int lat;
        int n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        tick(); tick();

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       {16'd0, sum},       32'd0);
        chk("rst_cout",      {31'd0, cout},      32'd0);
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        tick();

        // Wrap to zero with carry out; latency measured from acceptance edge
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk("latency", lat, 32'd4);
        tick();

        // Signed overflow and subtraction with cin ignored
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        repeat (8) tick();
        chk("directed_drained", q.size(), 32'd0);

        // Reset with three sets in flight
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h4321, 16'h0F0F, 1'b1, 1'b0);
        send(16'hAAAA, 16'h5555, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum",       {16'd0, sum},       32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end
        tick();

        // Stall with four results pending, then drain back-to-back
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'(i * 16'h1111 + 3), 16'(16'h0102 << i), 1'(i), 1'b0);
        @(negedge clk);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        @(negedge clk);
        chk("drain_done", {31'd0, out_valid}, 32'd0);
        tick();

        // Random back-to-back traffic with random output backpressure
        rnd_ready = 1;
        for (int i = 0; i < 20; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rnd_ready = 0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("random_drained", q.size(), 32'd0);

        // Single-stage build: latency 1
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
        @(negedge clk);
        chk("w8_in_ready", {31'd0, in_ready8}, 32'd1);
        tick();
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("w8_out_valid", {31'd0, out_valid8}, 32'd1);
        chk("w8_sum",       {24'd0, sum8},       32'h0000_00FF);
        chk("w8_cout",      {31'd0, cout8},      32'd1);
        chk("w8_ovf",       {31'd0, ovf8},       32'd0);
        tick();
        a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b1; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("w8_sub_sum",  {24'd0, sum8},  32'h0000_007F);
        chk("w8_sub_cout", {31'd0, cout8}, 32'd1);
        chk("w8_sub_ovf",  {31'd0, ovf8},  32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
